// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - shares one single-port BRAM between instruction fetch and load/store ports
module bram_arbiter #(
  parameter int ADDR_WIDTH   = 18,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    bram_enable,
  output logic [DATA_WIDTH/8-1:0] bram_we,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_wdata,
  input  logic [DATA_WIDTH-1:0]   bram_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  owner_e     rd_owner_q, rd_owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       starved;

  // Arbitration: data wins unless fetch has lost STARVE_LIMIT times in a row
  always_comb begin
    if_gnt  = 1'b0;
    d_gnt   = 1'b0;
    starved = (starve_cnt_q == LIMIT);
    if (n_reset) begin
      if (d_req && !(if_req && starved)) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // BRAM port mux from whichever requester holds the grant; zeros when idle
  always_comb begin
    bram_enable = if_gnt | d_gnt;
    bram_we     = '0;
    bram_addr   = '0;
    bram_wdata  = '0;
    if (if_gnt) begin
      bram_addr = if_addr;
    end else if (d_gnt) begin
      bram_addr  = d_addr;
      bram_wdata = d_wdata;
      bram_we    = d_we ? d_be : '0;
    end
  end

  // Next read owner and starvation count
  always_comb begin
    rd_owner_d   = OWN_NONE;
    starve_cnt_d = starve_cnt_q;
    if (if_gnt) begin
      rd_owner_d = OWN_IF;
    end else if (d_gnt && !d_we) begin
      rd_owner_d = OWN_D;
    end
    if (!if_req || if_gnt) begin
      starve_cnt_d = '0;
    end else if (d_gnt && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // State registers; async reset drops any in-flight read response
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_owner_q   <= OWN_NONE;
      starve_cnt_q <= '0;
    end else begin
      rd_owner_q   <= rd_owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Route the BRAM read data to the port that issued the read one cycle earlier
  always_comb begin
    if_rvalid = (rd_owner_q == OWN_IF);
    d_rvalid  = (rd_owner_q == OWN_D);
    if_rdata  = if_rvalid ? bram_rdata : '0;
    d_rdata   = d_rvalid  ? bram_rdata : '0;
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - scoreboard bench for bram_arbiter with a behavioural BRAM
module tb_bram_arbiter;

  logic        clk;
  logic        n_reset;
  logic        if_req;
  logic [17:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [17:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        bram_enable;
  logic [3:0]  bram_we;
  logic [17:0] bram_addr;
  logic [31:0] bram_wdata;
  logic [31:0] bram_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [31:0] mem[int];
  logic [31:0] ref_mem[int];

  bram_arbiter #(.ADDR_WIDTH(18), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .n_reset(n_reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .bram_enable(bram_enable), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [17:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [17:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [17:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic void ref_wr(input logic [17:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = ref_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[int'(a)] = w;
  endfunction

  // Write-first BRAM with one-cycle read latency
  always @(posedge clk) begin : bram_model
    logic [31:0] w;
    if (bram_enable) begin
      w = mem_rd(bram_addr);
      for (int b = 0; b < 4; b++) if (bram_we[b]) w[8*b +: 8] = bram_wdata[8*b +: 8];
      if (|bram_we) mem[int'(bram_addr)] = w;
      bram_rdata <= w;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: check responses of the previous grant, drive, check grant and BRAM drive
  task automatic step(input logic ifr, input logic [17:0] ifa,
                      input logic dr, input logic dwe, input logic [17:0] da,
                      input logic [31:0] dwd, input logic [3:0] dbe,
                      input logic eif, input logic ed, input logic rst_after);
    check("if_rvalid", 64'(if_rvalid), 64'(if_q.size() != 0));
    if (if_q.size() != 0) check("if_rdata", 64'(if_rdata), 64'(if_q.pop_front()));
    else                  check("if_rdata_zero", 64'(if_rdata), 64'(0));
    check("d_rvalid", 64'(d_rvalid), 64'(d_q.size() != 0));
    if (d_q.size() != 0) check("d_rdata", 64'(d_rdata), 64'(d_q.pop_front()));
    else                 check("d_rdata_zero", 64'(d_rdata), 64'(0));

    if_req  = ifr;
    if_addr = ifa;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;
    d_be    = dbe;
    #2;
    check("if_gnt", 64'(if_gnt), 64'(eif));
    check("d_gnt", 64'(d_gnt), 64'(ed));
    check("bram_enable", 64'(bram_enable), 64'(eif | ed));
    if (eif) begin
      check("bram_addr_if", 64'(bram_addr), 64'(ifa));
      check("bram_we_if", 64'(bram_we), 64'(0));
      if_q.push_back(ref_rd(ifa));
    end else if (ed) begin
      check("bram_addr_d", 64'(bram_addr), 64'(da));
      check("bram_we_d", 64'(bram_we), 64'(dwe ? dbe : 4'b0));
      if (dwe) begin
        check("bram_wdata", 64'(bram_wdata), 64'(dwd));
        ref_wr(da, dwd, dbe);
      end else begin
        d_q.push_back(ref_rd(da));
      end
    end else begin
      check("bram_addr_idle", 64'(bram_addr), 64'(0));
      check("bram_wdata_idle", 64'(bram_wdata), 64'(0));
      check("bram_we_idle", 64'(bram_we), 64'(0));
    end
    if (rst_after) begin
      n_reset = 1'b0;
      if_q.delete();
      d_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 18'h0, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  logic        e;
  logic [17:0] fa;
  int          dk;

  initial begin
    n_reset = 1'b0;
    if_req = 1'b1; if_addr = 18'h00010;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;

    // Fetch held through reset: no grant, then granted on release
    step(1'b1, 18'h00010, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 18'h00010, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    n_reset = 1'b1;
    step(1'b1, 18'h00010, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    idle();

    // Full-word write, idle, read back
    step(1'b0, 18'h0, 1'b1, 1'b1, 18'h00020, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b1, 1'b0);
    idle();
    step(1'b0, 18'h0, 1'b1, 1'b0, 18'h00020, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    idle();
    check("ref_full_word", 64'(ref_rd(18'h00020)), 64'h0000_0000_DEADBEEF);

    // Byte-lane write merged into an existing word, then read
    step(1'b0, 18'h0, 1'b1, 1'b1, 18'h00040, 32'h11223344, 4'b1111, 1'b0, 1'b1, 1'b0);
    step(1'b0, 18'h0, 1'b1, 1'b1, 18'h00040, 32'h0000AB00, 4'b0010, 1'b0, 1'b1, 1'b0);
    step(1'b0, 18'h0, 1'b1, 1'b0, 18'h00040, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
    idle();
    check("ref_byte_merge", 64'(ref_rd(18'h00040)), 64'h0000_0000_1122AB44);

    // Both requesting: D,D,D,D,IF repeating
    fa = 18'h00100;
    dk = 0;
    for (int i = 0; i < 15; i++) begin
      e = ((i % 5) == 4);
      step(1'b1, fa, 1'b1, 1'b0, 18'(18'h00200 + dk), 32'h0, 4'h0, e, !e, 1'b0);
      if (e) fa = fa + 18'd1;
      else   dk++;
    end
    idle();

    // Alternating single-port reads each cycle
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 18'h00001, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 18'h0, 1'b1, 1'b0, 18'h00002, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    end
    idle();

    // Build up starvation, then reset right after a data-read grant
    step(1'b1, 18'h00300, 1'b1, 1'b0, 18'h00030, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 18'h00300, 1'b1, 1'b0, 18'h00031, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 18'h00300, 1'b1, 1'b0, 18'h00032, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 18'h00300, 1'b1, 1'b0, 18'h00033, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 18'h00300, 1'b1, 1'b0, 18'h00033, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    n_reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e = (i == 4);
      step(1'b1, 18'h00300, 1'b1, 1'b0, 18'(18'h00033 + i), 32'h0, 4'h0, e, !e, 1'b0);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares the single-port instruction/data block RAM between the CPU instruction-fetch port and the load/store data port.
- One grant per cycle; reads are pipelined with fixed 1-cycle BRAM read latency; read data is routed back to the owning requester.
- Data port has priority. A starvation counter forces a fetch grant after STARVE_LIMIT consecutive data wins.
- Sits between the cpu core and the bram instance (word address = byte address >> 2).

Parameters:
- ADDR_WIDTH, 18, BRAM word-address width
- DATA_WIDTH, 32, data word width (byte enables = DATA_WIDTH/8)
- STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced (1..15)

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- if_req  in  1  fetch read request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_WIDTH  fetch word address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  if_rdata valid (registered)
- if_rdata  out  DATA_WIDTH  fetch read data
- d_req  in  1  data request; held with addr/we/wdata/be stable until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_WIDTH  data word address
- d_wdata  in  DATA_WIDTH  write data
- d_be  in  DATA_WIDTH/8  write byte enables
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  d_rdata valid (registered); never asserted for writes
- d_rdata  out  DATA_WIDTH  data read data
- bram_enable  out  1  BRAM access this cycle
- bram_we  out  DATA_WIDTH/8  BRAM byte write enables
- bram_addr  out  ADDR_WIDTH  BRAM word address
- bram_wdata  out  DATA_WIDTH  BRAM write data
- bram_rdata  in  DATA_WIDTH  BRAM read data, valid 1 cycle after enabled read

Behaviour:
- Reset values (asserted asynchronously): if_rvalid = 0, d_rvalid = 0, rd_owner = NONE, starve_cnt = 0.
- While n_reset is low: grants = 0 and bram_enable = 0.
- Arbitration, combinational in the request cycle:
  - only d_req: data granted.
  - only if_req: fetch granted.
  - both, starve_cnt < STARVE_LIMIT: data granted.
  - both, starve_cnt == STARVE_LIMIT: fetch granted.
  - Never both grants in one cycle.
- BRAM drive:
  - bram_enable = if_gnt | d_gnt.
  - bram_addr / bram_wdata are muxed from the granted port.
  - bram_we = d_be when the data port is granted with d_we = 1, otherwise 0.
  - Idle cycle: addr = 0, wdata = 0.
- rd_owner register:
  - Set each cycle to IF (fetch granted), D (data read granted) or NONE (write or no grant).
  - Next cycle: if_rvalid = (rd_owner == IF), d_rvalid = (rd_owner == D).
  - rdata = bram_rdata on the owning port; the other port's rdata = 0.
- Throughput: back-to-back grants every cycle. Read response always exactly 1 cycle after grant, independent of the next cycle's grant.
- starve_cnt:
  - +1 when data is granted while if_req = 1.
  - Cleared when fetch is granted or if_req = 0.
  - Saturates at STARVE_LIMIT.
- Write then read of the same address on consecutive cycles returns the new data (BRAM write-first is required of the BRAM, not the arbiter).
- Reset mid-read: pending rvalid is dropped and never emitted after reset release; the first cycle after release arbitrates normally.
- Requester dropping req before its grant is legal; the request is forgotten with no state change other than starve_cnt clearing if if_req drops.

Test Plan:
- Reset with if_req = 1 held: no grant, bram_enable = 0. After release: if_gnt = 1 at addr 0x00010; next cycle if_rvalid = 1, if_rdata = mem[0x00010].
- Single data write d_addr = 0x00020, d_wdata = 0xDEADBEEF, d_be = 4'b1111 → d_gnt = 1, bram_we = 4'b1111, no d_rvalid. Read of 0x00020 two cycles later → d_rdata = 0xDEADBEEF.
- Byte write d_be = 4'b0010, d_wdata = 0x0000AB00 onto 0x11223344 → subsequent read returns 0x1122AB44.
- Both requesting continuously, STARVE_LIMIT = 4 → grant pattern D,D,D,D,IF repeating. Each rvalid lands on the correct port 1 cycle after its grant.
- Alternating fetch/data reads every cycle at 0x1/0x2 → 1 grant/cycle. if_rvalid/d_rvalid alternate with matching data, no overlap.
- Assert n_reset low the cycle after a data-read grant → d_rvalid stays 0 through reset and after release; starve_cnt restarts at 0.
